// File: rtl/prio_arbiter.sv
// rtl/prio_arbiter.sv - registered N-input priority / round-robin arbiter with hold timer
module prio_arbiter #(
  parameter int N        = 8,
  parameter int W        = $clog2(N),
  parameter int MODE     = 0,
  parameter int MAX_HOLD = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic         grant_valid,
  output logic [W-1:0] grant_idx,
  output logic [N-1:0] grant_onehot,
  output logic         any_req,
  output logic         preempt
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [15:0]  HOLD_LAST = (MAX_HOLD == 0) ? 16'd0 : 16'(MAX_HOLD - 1);
  localparam logic [W-1:0] LAST_IDX  = W'(N - 1);
  localparam logic [N-1:0] ONE       = N'(1);

  state_t       state_q, state_d;
  logic [W-1:0] rr_ptr_q, rr_ptr_d;
  logic [15:0]  hold_q, hold_d;
  logic         grant_valid_q, grant_valid_d;
  logic [W-1:0] grant_idx_q, grant_idx_d;
  logic [N-1:0] grant_onehot_q, grant_onehot_d;
  logic         any_req_q, any_req_d;
  logic         preempt_q, preempt_d;

  logic         win_found;
  logic [W-1:0] win_idx;
  logic [N-1:0] rot;
  logic [W:0]   sum;
  logic         owner_req;
  logic         timer_hit;

  // Winner selection: highest set bit, or first set bit at/after rr_ptr with wrap
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    rot       = N'({req, req} >> rr_ptr_q);
    if (MODE == 0) begin
      for (int k = 0; k < N; k++) begin
        if (req[k]) begin
          win_found = 1'b1;
          win_idx   = W'(k);
        end
      end
    end else begin
      // Descending scan so the last hit is the closest to rr_ptr
      for (int k = N - 1; k >= 0; k--) begin
        if (rot[k]) begin
          win_found = 1'b1;
          sum       = {1'b0, rr_ptr_q} + (W+1)'(k);
          if (sum >= (W+1)'(N)) begin
            sum = sum - (W+1)'(N);
          end
          win_idx = sum[W-1:0];
        end
      end
    end
  end

  // Release conditions while a grant is held
  always_comb begin
    owner_req = |(grant_onehot_q & req);
    timer_hit = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    hold_d         = hold_q;
    grant_valid_d  = grant_valid_q;
    grant_idx_d    = grant_idx_q;
    grant_onehot_d = grant_onehot_q;
    any_req_d      = |req;
    preempt_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d        = GRANT;
          grant_valid_d  = 1'b1;
          grant_idx_d    = win_idx;
          grant_onehot_d = ONE << win_idx;
          hold_d         = '0;
        end
      end
      GRANT: begin
        if (done || !owner_req || timer_hit) begin
          state_d        = IDLE;
          grant_valid_d  = 1'b0;
          grant_idx_d    = '0;
          grant_onehot_d = '0;
          hold_d         = '0;
          preempt_d      = timer_hit;
          if (MODE == 1) begin
            rr_ptr_d = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + W'(1);
          end
        end else begin
          hold_d = (hold_q == 16'hFFFF) ? hold_q : hold_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      hold_q         <= '0;
      grant_valid_q  <= 1'b0;
      grant_idx_q    <= '0;
      grant_onehot_q <= '0;
      any_req_q      <= 1'b0;
      preempt_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      hold_q         <= hold_d;
      grant_valid_q  <= grant_valid_d;
      grant_idx_q    <= grant_idx_d;
      grant_onehot_q <= grant_onehot_d;
      any_req_q      <= any_req_d;
      preempt_q      <= preempt_d;
    end
  end

  assign grant_valid  = grant_valid_q;
  assign grant_idx    = grant_idx_q;
  assign grant_onehot = grant_onehot_q;
  assign any_req      = any_req_q;
  assign preempt      = preempt_q;

endmodule

// File: tb/tb_prio_arbiter.sv
// tb/tb_prio_arbiter.sv - directed self-checking bench for prio_arbiter
module tb_prio_arbiter;

  logic clk;
  logic rst_n;

  logic [3:0] fp_req;
  logic       fp_done;
  logic       fp_valid;
  logic [1:0] fp_idx;
  logic [3:0] fp_oh;
  logic       fp_any;
  logic       fp_pre;

  logic [4:0] rr_req;
  logic       rr_done;
  logic       rr_valid;
  logic [2:0] rr_idx;
  logic [4:0] rr_oh;
  logic       rr_any;
  logic       rr_pre;

  logic [3:0] to_req;
  logic       to_done;
  logic       to_valid;
  logic [1:0] to_idx;
  logic [3:0] to_oh;
  logic       to_any;
  logic       to_pre;

  int n_checks;
  int n_pass;

  prio_arbiter #(.N(4), .MODE(0), .MAX_HOLD(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .req(fp_req), .done(fp_done),
    .grant_valid(fp_valid), .grant_idx(fp_idx), .grant_onehot(fp_oh),
    .any_req(fp_any), .preempt(fp_pre)
  );

  prio_arbiter #(.N(5), .MODE(1), .MAX_HOLD(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(rr_req), .done(rr_done),
    .grant_valid(rr_valid), .grant_idx(rr_idx), .grant_onehot(rr_oh),
    .any_req(rr_any), .preempt(rr_pre)
  );

  prio_arbiter #(.N(4), .MODE(0), .MAX_HOLD(3)) u_to (
    .clk(clk), .rst_n(rst_n), .req(to_req), .done(to_done),
    .grant_valid(to_valid), .grant_idx(to_idx), .grant_onehot(to_oh),
    .any_req(to_any), .preempt(to_pre)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rr_seq [6] = '{0, 1, 2, 3, 4, 0};
    n_checks = 0;
    n_pass   = 0;
    fp_done  = 1'b0;
    rr_done  = 1'b0;
    to_done  = 1'b0;
    to_req   = 4'b0000;
    fp_req   = 4'b1111;
    rr_req   = 5'b11111;
    rst_n    = 1'b0;

    // reset with all requests high
    #12;
    check("rst_fp_valid", 32'(fp_valid), 32'd0);
    check("rst_fp_idx",   32'(fp_idx),   32'd0);
    check("rst_fp_oh",    32'(fp_oh),    32'd0);
    check("rst_fp_any",   32'(fp_any),   32'd0);
    check("rst_fp_pre",   32'(fp_pre),   32'd0);
    check("rst_rr_valid", 32'(rr_valid), 32'd0);
    check("rst_rr_oh",    32'(rr_oh),    32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_fp_valid", 32'(fp_valid), 32'd1);
    check("post_rst_fp_idx",   32'(fp_idx),   32'd3);
    check("post_rst_fp_oh",    32'(fp_oh),    32'd8);
    check("post_rst_fp_any",   32'(fp_any),   32'd1);
    check("post_rst_rr_idx",   32'(rr_idx),   32'd0);
    check("post_rst_rr_oh",    32'(rr_oh),    32'd1);
    fp_req = 4'b0000;
    rr_req = 5'b00000;
    tick();
    check("drop_fp_valid", 32'(fp_valid), 32'd0);
    check("drop_rr_valid", 32'(rr_valid), 32'd0);
    tick();

    // fixed priority, owner stays put when a higher request arrives
    fp_req = 4'b0110;
    tick();
    check("fp_idx_2", 32'(fp_idx), 32'd2);
    check("fp_oh_2",  32'(fp_oh),  32'd4);
    fp_req = 4'b1110;
    tick();
    check("fp_hold_idx",   32'(fp_idx),   32'd2);
    check("fp_hold_valid", 32'(fp_valid), 32'd1);
    fp_done = 1'b1;
    tick();
    fp_done = 1'b0;
    check("fp_idle_valid", 32'(fp_valid), 32'd0);
    check("fp_idle_idx",   32'(fp_idx),   32'd0);
    tick();
    check("fp_regrant_idx",   32'(fp_idx),   32'd3);
    check("fp_regrant_valid", 32'(fp_valid), 32'd1);
    fp_req = 4'b0000;
    tick();
    tick();

    // withdrawal without done
    fp_req = 4'b0100;
    tick();
    check("wd_idx", 32'(fp_idx), 32'd2);
    fp_req = 4'b0000;
    tick();
    check("wd_valid", 32'(fp_valid), 32'd0);
    check("wd_pre",   32'(fp_pre),   32'd0);
    tick();

    // asynchronous reset mid-grant clears the rr pointer (currently 1)
    rr_req = 5'b00100;
    tick();
    check("ar_pre_idx",   32'(rr_idx),   32'd2);
    check("ar_pre_valid", 32'(rr_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(rr_valid), 32'd0);
    check("ar_idx",   32'(rr_idx),   32'd0);
    check("ar_oh",    32'(rr_oh),    32'd0);
    rr_req = 5'b11111;
    rst_n  = 1'b1;
    tick();

    // round-robin across a non-power-of-two width
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rr_idx_%0d", i), 32'(rr_idx), 32'(rr_seq[i]));
      check($sformatf("rr_valid_%0d", i), 32'(rr_valid), 32'd1);
      rr_done = 1'b1;
      tick();
      rr_done = 1'b0;
      check($sformatf("rr_gap_%0d", i), 32'(rr_valid), 32'd0);
      tick();
    end
    rr_req = 5'b00000;
    tick();
    tick();

    // hold timer expiry
    to_req = 4'b0010;
    tick();
    check("to_c1_valid", 32'(to_valid), 32'd1);
    check("to_c1_idx",   32'(to_idx),   32'd1);
    check("to_c1_pre",   32'(to_pre),   32'd0);
    tick();
    check("to_c2_valid", 32'(to_valid), 32'd1);
    tick();
    check("to_c3_valid", 32'(to_valid), 32'd1);
    tick();
    check("to_exp_valid", 32'(to_valid), 32'd0);
    check("to_exp_pre",   32'(to_pre),   32'd1);
    tick();
    check("to_regrant_valid", 32'(to_valid), 32'd1);
    check("to_regrant_pre",   32'(to_pre),   32'd0);
    tick();
    check("to_b_c2_valid", 32'(to_valid), 32'd1);
    tick();
    check("to_b_c3_valid", 32'(to_valid), 32'd1);
    to_done = 1'b1;
    tick();
    to_done = 1'b0;
    check("to_done_valid", 32'(to_valid), 32'd0);
    check("to_done_pre",   32'(to_pre),   32'd1);
    tick();
    check("to_done_regrant", 32'(to_valid), 32'd1);
    check("to_done_pre_off", 32'(to_pre),   32'd0);
    to_req = 4'b0000;
    tick();
    check("to_final_valid", 32'(to_valid), 32'd0);
    check("to_final_pre",   32'(to_pre),   32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
